reg_file_multiport: RTL and testbench



---
 rtl/reg_file_multiport_if.sv | 30 +++
 rtl/reg_file_multiport.sv | 107 ++++++++++
 tb/tb_reg_file_multiport.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_multiport_if.sv
// Register file port bundle: read selects/data, write ports, stall and clear control.
// The master side belongs to decode/writeback; the slave side is the register file.
interface reg_file_multiport_if #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned NUM_READ_PORTS  = 3,
    parameter int unsigned NUM_WRITE_PORTS = 2
);
    localparam int unsigned SEL_WIDTH = $clog2(NUM_REGS);

    logic                                  stall;
    logic                                  clear_req;
    logic                                  busy;
    logic [NUM_READ_PORTS*SEL_WIDTH-1:0]   read_sel;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  read_data_async;
    logic [NUM_WRITE_PORTS-1:0]            write_en;
    logic [NUM_WRITE_PORTS*SEL_WIDTH-1:0]  write_sel;
    logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] write_data;

    modport master (
        output stall, clear_req, read_sel, write_en, write_sel, write_data,
        input  busy, read_data, read_data_async
    );

    modport slave (
        input  stall, clear_req, read_sel, write_en, write_sel, write_data,
        output busy, read_data, read_data_async
    );
endinterface

// File: rtl/reg_file_multiport.sv
// Multi-port register file: prioritised writes, registered reads with write-first bypass
// and stall-hold, combinational reads, and a sequenced clear engine after reset/on request.
module reg_file_multiport #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned NUM_READ_PORTS  = 3,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter bit          HARDWIRE_ZERO   = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    reg_file_multiport_if.slave bus
);
    localparam int unsigned SEL_WIDTH = $clog2(NUM_REGS);

    typedef logic [SEL_WIDTH-1:0]  sel_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e state_q, state_d;
    sel_t   clear_idx_q, clear_idx_d;
    data_t  regs_q [NUM_REGS];
    data_t  regs_d [NUM_REGS];
    data_t  rd_q   [NUM_READ_PORTS];
    data_t  rd_next[NUM_READ_PORTS];

    sel_t   rd_sel [NUM_READ_PORTS];
    sel_t   wr_sel [NUM_WRITE_PORTS];
    data_t  wr_data[NUM_WRITE_PORTS];

    for (genvar w = 0; w < NUM_WRITE_PORTS; w++) begin : g_wr
        assign wr_sel[w]  = bus.write_sel[w*SEL_WIDTH +: SEL_WIDTH];
        assign wr_data[w] = bus.write_data[w*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        assign rd_sel[p] = bus.read_sel[p*SEL_WIDTH +: SEL_WIDTH];
        assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
        assign bus.read_data_async[p*DATA_WIDTH +: DATA_WIDTH] =
            (HARDWIRE_ZERO && rd_sel[p] == '0) ? '0 : regs_q[rd_sel[p]];
    end

    assign bus.busy = (state_q == StClear);

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            StClear: begin
                clear_idx_d = clear_idx_q + sel_t'(1);
                if (clear_idx_q == sel_t'(NUM_REGS - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (bus.clear_req) begin
                    state_d     = StClear;
                    clear_idx_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Ascending port order lets the highest-index writer land last and win.
    always_comb begin
        regs_d = regs_q;
        if (state_q == StClear) begin
            regs_d[clear_idx_q] = '0;
        end else begin
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (bus.write_en[w] && !(HARDWIRE_ZERO && wr_sel[w] == '0)) begin
                    regs_d[wr_sel[w]] = wr_data[w];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_next[p] = regs_q[rd_sel[p]];
            for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
                if (bus.write_en[w] && wr_sel[w] == rd_sel[p]) rd_next[p] = wr_data[w];
            end
            if (HARDWIRE_ZERO && rd_sel[p] == '0) rd_next[p] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StClear;
            clear_idx_q <= '0;
            for (int p = 0; p < NUM_READ_PORTS; p++) rd_q[p] <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            if (!bus.stall) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    rd_q[p] <= (state_q == StIdle) ? rd_next[p] : '0;
                end
            end
        end
    end

    // Storage has no reset of its own; the clear engine zeroes it once rst drops.
    always_ff @(posedge clk) begin
        if (!rst) regs_q <= regs_d;
    end
endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed and randomised checks of reg_file_multiport in three parameter configurations.
module tb_reg_file_multiport;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    reg_file_multiport_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3),
                            .NUM_WRITE_PORTS(2)) ifa ();
    reg_file_multiport_if #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3),
                            .NUM_WRITE_PORTS(2)) ifb ();
    reg_file_multiport_if #(.DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ_PORTS(4),
                            .NUM_WRITE_PORTS(3)) ifc ();

    reg_file_multiport #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3),
                         .NUM_WRITE_PORTS(2), .HARDWIRE_ZERO(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_multiport #(.DATA_WIDTH(32), .NUM_REGS(16), .NUM_READ_PORTS(3),
                         .NUM_WRITE_PORTS(2), .HARDWIRE_ZERO(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    reg_file_multiport #(.DATA_WIDTH(64), .NUM_REGS(32), .NUM_READ_PORTS(4),
                         .NUM_WRITE_PORTS(3), .HARDWIRE_ZERO(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the wide configuration.
    logic [63:0]  mem_c [32];
    logic [63:0]  exp_rd_c [4];
    int unsigned  ws [3];
    int unsigned  rs [4];
    bit           we [3];
    logic [63:0]  wd [3];
    logic [255:0] exp_v;
    logic [255:0] exp_av;
    int           n;
    bit           st;
    bit           hit;

    initial begin
        ifa.stall = 0; ifa.clear_req = 0; ifa.read_sel = '0;
        ifa.write_en = '0; ifa.write_sel = '0; ifa.write_data = '0;
        ifb.stall = 0; ifb.clear_req = 0; ifb.read_sel = '0;
        ifb.write_en = '0; ifb.write_sel = '0; ifb.write_data = '0;
        ifc.stall = 0; ifc.clear_req = 0; ifc.read_sel = '0;
        ifc.write_en = '0; ifc.write_sel = '0; ifc.write_data = '0;
        for (int i = 0; i < 32; i++) mem_c[i] = '0;
        for (int i = 0; i < 4; i++) exp_rd_c[i] = '0;

        // 1: reset, then the clear sequence; a write during CLEAR is lost
        rst = 1;
        tick();
        tick();
        check("rst_busy", 256'(ifa.busy), 256'(1));
        check("rst_rd", 256'(ifa.read_data), 256'(0));
        ifa.write_en = 2'b01; ifa.write_sel = {4'd0, 4'd3}; ifa.write_data = {32'd0, 32'hAA};
        rst = 0;
        n = 0;
        while (ifa.busy && n < 100) begin
            tick();
            n++;
        end
        ifa.write_en = '0;
        check("clear_len", 256'(n), 256'(16));
        for (int r = 0; r < 16; r++) begin
            ifa.read_sel = {3{4'(r)}};
            tick();
            check($sformatf("clr_rd%0d", r), 256'(ifa.read_data), 256'(0));
            check($sformatf("clr_ra%0d", r), 256'(ifa.read_data_async), 256'(0));
        end

        // 2: same-target writes, highest port wins, bypassed to the sync read
        ifa.write_en = 2'b11; ifa.write_sel = {4'd5, 4'd5}; ifa.write_data = {32'h22, 32'h11};
        ifa.read_sel = {4'd0, 4'd0, 4'd5};
        tick();
        check("byp_rd", 256'(ifa.read_data[31:0]), 256'(32'h22));
        check("byp_ra", 256'(ifa.read_data_async[31:0]), 256'(32'h22));
        ifa.write_en = '0;
        ifa.read_sel = {4'd5, 4'd0, 4'd0};
        tick();
        check("prio_store", 256'(ifa.read_data[95:64]), 256'(32'h22));

        // 3: register 0, hardwired vs ordinary
        ifa.write_en = 2'b01; ifa.write_sel = '0; ifa.write_data = {32'd0, 32'hFFFF_FFFF};
        ifb.write_en = 2'b01; ifb.write_sel = '0; ifb.write_data = {32'd0, 32'hFFFF_FFFF};
        ifa.read_sel = '0; ifb.read_sel = '0;
        tick();
        check("z_byp_a", 256'(ifa.read_data), 256'(0));
        check("z_byp_b", 256'(ifb.read_data), 256'({3{32'hFFFF_FFFF}}));
        ifa.write_en = '0; ifb.write_en = '0;
        tick();
        check("z_rd_a", 256'(ifa.read_data), 256'(0));
        check("z_ra_a", 256'(ifa.read_data_async), 256'(0));
        check("z_rd_b", 256'(ifb.read_data), 256'({3{32'hFFFF_FFFF}}));
        check("z_ra_b", 256'(ifb.read_data_async), 256'({3{32'hFFFF_FFFF}}));

        // 4: stall holds read_data; writes still land
        ifa.write_en = 2'b01; ifa.write_sel = {4'd0, 4'd7}; ifa.write_data = {32'd0, 32'h55};
        ifa.read_sel = {4'd0, 4'd7, 4'd0};
        tick();
        ifa.write_en = '0;
        tick();
        check("st_pre", 256'(ifa.read_data[63:32]), 256'(32'h55));
        ifa.stall = 1;
        ifa.write_en = 2'b01; ifa.write_data = {32'd0, 32'h66};
        tick();
        ifa.write_en = '0;
        check("st_hold", 256'(ifa.read_data[63:32]), 256'(32'h55));
        check("st_async", 256'(ifa.read_data_async[63:32]), 256'(32'h66));
        tick();
        check("st_hold2", 256'(ifa.read_data[63:32]), 256'(32'h55));
        ifa.stall = 0;
        tick();
        check("st_rel", 256'(ifa.read_data[63:32]), 256'(32'h66));

        // 5: clear_req, reset mid-clear at index 8, ignored clear_req pulses
        ifa.clear_req = 1;
        tick();
        ifa.clear_req = 0;
        check("creq_busy", 256'(ifa.busy), 256'(1));
        repeat (8) tick();
        rst = 1;
        tick();
        rst = 0;
        n = 0;
        while (ifa.busy && n < 100) begin
            tick();
            n++;
            ifa.clear_req = (n == 5 || n == 10);
            if (n == 3) check("mid_rd", 256'(ifa.read_data), 256'(0));
        end
        ifa.clear_req = 0;
        check("reclear_len", 256'(n), 256'(16));
        tick();
        check("idle_after", 256'(ifa.busy), 256'(0));
        for (int r = 0; r < 16; r++) begin
            ifa.read_sel = {3{4'(r)}};
            tick();
            check($sformatf("rc_rd%0d", r), 256'(ifa.read_data), 256'(0));
            check($sformatf("rc_ra%0d", r), 256'(ifa.read_data_async), 256'(0));
        end

        // 6: wide configuration, random traffic against the model
        n = 0;
        while (ifc.busy && n < 100) begin
            tick();
            n++;
        end
        check("c_idle", 256'(ifc.busy), 256'(0));
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int w = 0; w < 3; w++) begin
                we[w] = ($urandom_range(0, 2) != 0);
                ws[w] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31);
                wd[w] = {$urandom, $urandom};
            end
            for (int r = 0; r < 4; r++) begin
                rs[r] = ($urandom_range(0, 2) == 0) ? ws[$urandom_range(0, 2)]
                                                    : $urandom_range(0, 31);
            end
            st = ($urandom_range(0, 4) == 0);
            if (!st) begin
                for (int r = 0; r < 4; r++) begin
                    if (rs[r] == 0) begin
                        exp_rd_c[r] = '0;
                    end else begin
                        hit = 0;
                        for (int w = 2; w >= 0; w--) begin
                            if (!hit && we[w] && ws[w] == rs[r]) begin
                                exp_rd_c[r] = wd[w];
                                hit = 1;
                            end
                        end
                        if (!hit) exp_rd_c[r] = mem_c[rs[r]];
                    end
                end
            end
            for (int w = 0; w < 3; w++) begin
                if (we[w] && ws[w] != 0) mem_c[ws[w]] = wd[w];
            end
            for (int r = 0; r < 4; r++) begin
                exp_v[r*64 +: 64]  = exp_rd_c[r];
                exp_av[r*64 +: 64] = (rs[r] == 0) ? 64'd0 : mem_c[rs[r]];
                ifc.read_sel[r*5 +: 5] = 5'(rs[r]);
            end
            for (int w = 0; w < 3; w++) begin
                ifc.write_en[w] = we[w];
                ifc.write_sel[w*5 +: 5] = 5'(ws[w]);
                ifc.write_data[w*64 +: 64] = wd[w];
            end
            ifc.stall = st;
            tick();
            check($sformatf("rnd_rd%0d", cyc), ifc.read_data, exp_v);
            check($sformatf("rnd_ra%0d", cyc), ifc.read_data_async, exp_av);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
